// File: rtl/line_buffer_ctrl_if.sv
// Line buffer controller bus: stream/config inputs and RAM-side outputs.
// master : the video-path side (drives enable, frame_start, in_valid, cfg_*)
// slave  : line_buffer_ctrl (drives RAM strobes/addresses, status flags)
interface line_buffer_ctrl_if #(
   parameter int unsigned WDEPTH = 640,
   parameter int unsigned ASIZE  = $clog2(WDEPTH),
   parameter int unsigned LSIZE  = $clog2(WDEPTH + 1)
);
   logic             enable;
   logic             frame_start;
   logic             in_valid;
   logic [LSIZE-1:0] cfg_len;
   logic             cfg_load;
   logic             ram_we;
   logic [ASIZE-1:0] ram_waddr;
   logic             ram_re;
   logic [ASIZE-1:0] ram_raddr;
   logic             out_valid;
   logic [LSIZE-1:0] fill_cnt;
   logic [1:0]       state_o;
   logic             cfg_err;

   modport master (
      output enable, frame_start, in_valid, cfg_len, cfg_load,
      input  ram_we, ram_waddr, ram_re, ram_raddr, out_valid, fill_cnt, state_o, cfg_err
   );

   modport slave (
      input  enable, frame_start, in_valid, cfg_len, cfg_load,
      output ram_we, ram_waddr, ram_re, ram_raddr, out_valid, fill_cnt, state_o, cfg_err
   );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Address/sequencing controller for a read-first RAM line buffer.
// Owns the circular write pointer, derives the L-delayed read address,
// tracks fill level and flags when RAM q holds a valid delayed sample.
// Ports:
//   Clock, Reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : enable/frame_start/in_valid/cfg_len/cfg_load in;
//                  ram_we/ram_waddr/ram_re/ram_raddr, out_valid, fill_cnt,
//                  state_o (00 IDLE, 01 FILL, 10 RUN), cfg_err out
module line_buffer_ctrl #(
   parameter int unsigned DSIZE  = 16,
   parameter int unsigned WDEPTH = 640,
   parameter int unsigned ASIZE  = $clog2(WDEPTH),
   parameter int unsigned LSIZE  = $clog2(WDEPTH + 1)
) (
   input logic               Clock,
   input logic               Reset,
   line_buffer_ctrl_if.slave bus
);
   localparam int unsigned XSIZE = ASIZE + 1;
   localparam logic [LSIZE-1:0] L_MAX   = LSIZE'(WDEPTH);
   localparam logic [LSIZE-1:0] L_MIN   = LSIZE'(1);
   localparam logic [ASIZE-1:0] WP_LAST = ASIZE'(WDEPTH - 1);

   // DSIZE only sizes the RAM instance; reject nonsense at elaboration.
   if (DSIZE == 0 || WDEPTH < 2) begin : g_param_check
      $error("line_buffer_ctrl: invalid DSIZE/WDEPTH");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FILL = 2'b01,
      ST_RUN  = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [ASIZE-1:0] wp_q, wp_d;
   logic [LSIZE-1:0] fill_q, fill_d;
   logic [LSIZE-1:0] l_act_q, l_act_d;
   logic [LSIZE-1:0] l_sh_q, l_sh_d;
   logic             pend_q, pend_d;
   logic             out_valid_q, out_valid_d;
   logic             cfg_err_q, cfg_err_d;

   logic             accept;
   logic             cfg_bad;
   logic [LSIZE-1:0] cfg_clamped;
   logic [LSIZE-1:0] l_new;
   logic             apply;
   logic             fs_flush;
   logic [LSIZE-1:0] l_eff;
   logic [ASIZE-1:0] wp_eff;
   logic [LSIZE-1:0] fill_eff;
   logic [XSIZE-1:0] wp_x, l_x, rd_x;

   // Clamp the requested length into 1..WDEPTH.
   always_comb begin
      cfg_bad     = 1'b0;
      cfg_clamped = bus.cfg_len;
      if (bus.cfg_len == '0) begin
         cfg_bad     = 1'b1;
         cfg_clamped = L_MIN;
      end else if (bus.cfg_len > L_MAX) begin
         cfg_bad     = 1'b1;
         cfg_clamped = L_MAX;
      end
   end

   // Effective pointer/length this cycle: a frame_start flush (and any
   // pending length) takes effect before a coincident sample is written.
   always_comb begin
      accept   = bus.in_valid & (state_q != ST_IDLE);
      l_new    = bus.cfg_load ? cfg_clamped : l_sh_q;
      apply    = bus.enable & (pend_q | bus.cfg_load) &
                 ((state_q == ST_IDLE) | bus.frame_start);
      fs_flush = bus.enable & bus.frame_start & (state_q != ST_IDLE);
      l_eff    = apply    ? l_new : l_act_q;
      wp_eff   = fs_flush ? '0    : wp_q;
      fill_eff = fs_flush ? '0    : fill_q;
   end

   // Delayed read address with wrap; L = WDEPTH lands on the write address.
   always_comb begin
      wp_x = XSIZE'(wp_eff);
      l_x  = XSIZE'(l_eff);
      if (wp_x >= l_x) rd_x = wp_x - l_x;
      else             rd_x = wp_x + XSIZE'(WDEPTH) - l_x;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      fill_d      = fill_q;
      l_act_d     = l_act_q;
      l_sh_d      = bus.cfg_load ? cfg_clamped : l_sh_q;
      pend_d      = pend_q | bus.cfg_load;
      out_valid_d = 1'b0;
      cfg_err_d   = cfg_err_q | (bus.cfg_load & cfg_bad);

      if (apply) begin
         l_act_d = l_new;
         pend_d  = 1'b0;
      end

      if (!bus.enable) begin
         state_d = ST_IDLE;
         wp_d    = '0;
         fill_d  = '0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_FILL;
         wp_d    = '0;
         fill_d  = '0;
      end else begin
         wp_d   = wp_eff;
         fill_d = fill_eff;
         if (accept) begin
            wp_d        = (wp_eff == WP_LAST) ? '0 : wp_eff + ASIZE'(1);
            out_valid_d = (fill_eff == l_eff);
            if (fill_eff != l_eff) fill_d = fill_eff + LSIZE'(1);
         end
         state_d = (fill_d == l_eff) ? ST_RUN : ST_FILL;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         wp_q        <= '0;
         fill_q      <= '0;
         l_act_q     <= L_MAX;
         l_sh_q      <= L_MAX;
         pend_q      <= 1'b0;
         out_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         fill_q      <= fill_d;
         l_act_q     <= l_act_d;
         l_sh_q      <= l_sh_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign bus.ram_we    = accept;
   assign bus.ram_re    = accept;
   assign bus.ram_waddr = wp_eff;
   assign bus.ram_raddr = ASIZE'(rd_x);
   assign bus.out_valid = out_valid_q;
   assign bus.fill_cnt  = fill_q;
   assign bus.state_o   = state_q;
   assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: read-first RAM model plus a stream-level
// scoreboard of delayed pixels, a vector table for the basic fill/run
// sequence, and hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_line_buffer_ctrl;
   localparam int WDEPTH = 640;
   localparam int ASIZE  = $clog2(WDEPTH);
   localparam int LSIZE  = $clog2(WDEPTH + 1);

   typedef struct {
      bit en; bit fs; bit iv; bit ld; int len;
      int exp_waddr; int exp_raddr; int exp_state; int exp_fill; bit exp_ov;
   } vec_t;

   logic Clock = 1'b0;
   logic Reset;
   always #5 Clock = ~Clock;

   line_buffer_ctrl_if #(.WDEPTH(WDEPTH)) bus ();

   line_buffer_ctrl #(.DSIZE(16), .WDEPTH(WDEPTH)) u_dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus)
   );

   // Read-first RAM model
   logic [15:0] mem [WDEPTH];
   logic [15:0] ram_q;
   logic [15:0] wdata;
   always @(posedge Clock) begin
      if (bus.ram_we) mem[bus.ram_waddr] <= wdata;
      if (bus.ram_re) ram_q <= mem[bus.ram_raddr];
   end

   int n_checks = 0;
   int n_errors = 0;

   // Stream-level reference state
   bit          m_active, m_pend;
   int          m_cnt, m_L, m_Lsh;
   logic [15:0] pix;
   logic [15:0] hist [$];
   logic [15:0] exp_q [$];

   vec_t tbl [9];

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_pend = 0; m_cnt = 0; m_L = WDEPTH; m_Lsh = WDEPTH;
      pix = '0; hist.delete(); exp_q.delete();
   endtask

   // One clock: drive at posedge+1, sample combinational outputs pre-edge,
   // registered outputs at the next posedge+1.
   task automatic tick(input bit en, input bit fs, input bit iv, input bit ld,
                       input int len, output int wa, output int ra);
      bit          was_active, exp_ov;
      int          c;
      logic [15:0] d;
      bus.enable = en; bus.frame_start = fs; bus.in_valid = iv;
      bus.cfg_load = ld; bus.cfg_len = LSIZE'(len);
      wdata = pix;
      was_active = m_active;
      exp_ov = 0;
      c = (len == 0) ? 1 : (len > WDEPTH) ? WDEPTH : len;
      if (ld) begin m_Lsh = c; m_pend = 1; end
      if (!en) begin
         m_active = 0; m_cnt = 0; hist.delete();
      end else begin
         if (!was_active || fs) begin
            if (m_pend) begin m_L = m_Lsh; m_pend = 0; end
            m_cnt = 0; hist.delete();
         end
         if (was_active && iv) begin
            hist.push_back(pix);
            m_cnt++;
            if (m_cnt > m_L) begin
               exp_q.push_back(hist[m_cnt - 1 - m_L]);
               exp_ov = 1;
            end
            pix++;
         end
         m_active = 1;
      end
      #2;
      chk("ram_we", int'(bus.ram_we), int'(was_active & iv));
      chk("ram_re", int'(bus.ram_re), int'(was_active & iv));
      wa = int'(bus.ram_waddr);
      ra = int'(bus.ram_raddr);
      @(posedge Clock);
      #1;
      chk("out_valid", int'(bus.out_valid), int'(exp_ov));
      if (exp_ov) begin
         d = exp_q.pop_front();
         if (bus.out_valid) chk("delayed_data", int'(ram_q), int'(d));
      end
      chk("fill_cnt", int'(bus.fill_cnt), (m_cnt > m_L) ? m_L : m_cnt);
      chk("state", int'(bus.state_o), !m_active ? 0 : (m_cnt >= m_L) ? 2 : 1);
   endtask

   task automatic run_table();
      int wa, ra;
      for (int i = 0; i < 9; i++) begin
         tick(tbl[i].en, tbl[i].fs, tbl[i].iv, tbl[i].ld, tbl[i].len, wa, ra);
         chk($sformatf("tbl%0d_waddr", i), wa, tbl[i].exp_waddr);
         chk($sformatf("tbl%0d_raddr", i), ra, tbl[i].exp_raddr);
         chk($sformatf("tbl%0d_state", i), int'(bus.state_o), tbl[i].exp_state);
         chk($sformatf("tbl%0d_fill", i), int'(bus.fill_cnt), tbl[i].exp_fill);
         chk($sformatf("tbl%0d_ov", i), int'(bus.out_valid), int'(tbl[i].exp_ov));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, int'(bus.state_o), 0);
      chk({tag, "_fill"}, int'(bus.fill_cnt), 0);
      chk({tag, "_ov"}, int'(bus.out_valid), 0);
      chk({tag, "_err"}, int'(bus.cfg_err), 0);
      chk({tag, "_waddr"}, int'(bus.ram_waddr), 0);
      chk({tag, "_raddr"}, int'(bus.ram_raddr), 0);
      chk({tag, "_we"}, int'(bus.ram_we), 0);
   endtask

   initial begin
      int wa, ra, first_ov, prev, acc;
      bit wrapped;
      bit ivg;

      //            en fs iv ld len  waddr raddr st fill ov
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 4,  0,   0, 0, 0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 636, 1, 0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  0, 636, 1, 1, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  1, 637, 1, 2, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  2, 638, 1, 3, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  3, 639, 2, 4, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  4,   0, 2, 4, 1'b1};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  5,   1, 2, 4, 1'b1};
      tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  6,   2, 2, 4, 1'b1};

      Reset = 1'b1;
      bus.enable = 0; bus.frame_start = 0; bus.in_valid = 0;
      bus.cfg_load = 0; bus.cfg_len = '0;
      wdata = '0;
      model_reset();
      repeat (3) @(posedge Clock);
      #1;
      chk_reset_vals("reset");
      Reset = 1'b0;

      // Basic L=4 fill/run
      run_table();

      // L=640: raddr tracks waddr, wrap 639->0, first valid after sample 641
      tick(1, 1, 0, 1, 640, wa, ra);
      first_ov = -1; prev = -1; wrapped = 0;
      for (int i = 1; i <= 1300; i++) begin
         tick(1, 0, 1, 0, 0, wa, ra);
         chk("l640_raddr_eq_waddr", ra, wa);
         if (prev == WDEPTH - 1 && wa == 0) wrapped = 1;
         prev = wa;
         if (bus.out_valid && first_ov < 0) first_ov = i;
      end
      chk("l640_wrap", int'(wrapped), 1);
      chk("l640_first_ov", first_ov, 641);
      chk("l640_fill_hold", int'(bus.fill_cnt), 640);

      // Reconfigure mid-RUN: old L=4 holds until frame_start
      tick(1, 1, 0, 1, 4, wa, ra);
      repeat (10) tick(1, 0, 1, 0, 0, wa, ra);
      tick(1, 0, 1, 1, 15, wa, ra);
      for (int i = 0; i < 5; i++) begin
         tick(1, 0, 1, 0, 0, wa, ra);
         chk("recfg_raddr_l4", ra, (wa + WDEPTH - 4) % WDEPTH);
         chk("recfg_fill_l4", int'(bus.fill_cnt), 4);
      end
      tick(1, 1, 0, 0, 0, wa, ra);
      chk("recfg_flush_fill", int'(bus.fill_cnt), 0);
      chk("recfg_flush_state", int'(bus.state_o), 1);
      for (int i = 1; i <= 15; i++) begin
         tick(1, 0, 1, 0, 0, wa, ra);
         if (i == 1) chk("recfg_flush_wp", wa, 0);
         if (i == 14) chk("recfg_fill14_state", int'(bus.state_o), 1);
         if (i == 15) chk("recfg_run15_state", int'(bus.state_o), 2);
      end

      // Clamps: 0 -> 1, 700 -> 640; cfg_err sticky
      tick(1, 1, 0, 1, 0, wa, ra);
      chk("clamp0_err", int'(bus.cfg_err), 1);
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 1, 0, 0, wa, ra);
         chk("clamp0_raddr", ra, (wa == 0) ? WDEPTH - 1 : wa - 1);
      end
      tick(1, 1, 0, 1, 700, wa, ra);
      chk("clamp700_err", int'(bus.cfg_err), 1);
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 1, 0, 0, wa, ra);
         chk("clamp700_raddr", ra, wa);
      end
      repeat (2) tick(0, 0, 1, 0, 0, wa, ra);
      chk("err_sticky_idle", int'(bus.cfg_err), 1);

      // frame_start coincident with a sample at wp=123
      tick(1, 1, 0, 1, 4, wa, ra);
      repeat (123) tick(1, 0, 1, 0, 0, wa, ra);
      tick(1, 0, 0, 0, 0, wa, ra);
      chk("coinc_wp123", wa, 123);
      tick(1, 1, 1, 0, 0, wa, ra);
      chk("coinc_fill", int'(bus.fill_cnt), 1);
      chk("coinc_ov", int'(bus.out_valid), 0);
      tick(1, 0, 0, 0, 0, wa, ra);
      chk("coinc_wp1", wa, 1);

      // Gapped input, L=5
      tick(1, 1, 0, 1, 5, wa, ra);
      acc = 0;
      for (int i = 0; i < 45; i++) begin
         ivg = (i % 3 == 0);
         tick(1, 0, ivg, 0, 0, wa, ra);
         chk("gap_waddr", wa, acc % WDEPTH);
         if (ivg) acc++;
         else chk("gap_ov_idle", int'(bus.out_valid), 0);
      end
      chk("gap_fill", int'(bus.fill_cnt), 5);

      // Reset mid-stream for 100 ns, then replay the basic sequence
      repeat (7) tick(1, 0, 1, 0, 0, wa, ra);
      Reset = 1'b1;
      #1;
      chk_reset_vals("midrst");
      bus.enable = 0; bus.in_valid = 0;
      #99;
      Reset = 1'b0;
      model_reset();
      run_table();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Address and sequencing controller for the RAM-based pixel line buffer (16-bit, 640-deep) used in the object-tracker video path. Owns the circular write pointer, computes the delayed read address for a programmable tap length, and tracks fill level. Flags when the delayed output is valid. Handles frame flush and safe runtime reconfiguration of the delay.

Parameters:
DSIZE, 16, pixel width; passed through for the RAM instance only, not used in control logic
WDEPTH, 640, RAM depth in words; maximum delay
ASIZE, $clog2(WDEPTH), RAM address width
LSIZE, $clog2(WDEPTH+1), width of the length and fill fields

Ports:
Clock  in  1  system clock; all logic on the rising edge
Reset  in  1  asynchronous, active-high reset
enable  in  1  controller run enable
frame_start  in  1  one-cycle start-of-frame pulse; flushes the buffer
in_valid  in  1  pixel present on the RAM write data this cycle
cfg_len  in  LSIZE  requested delay length L in samples
cfg_load  in  1  one-cycle pulse; captures cfg_len
ram_we  out  1  RAM write enable
ram_waddr  out  ASIZE  RAM write address
ram_re  out  1  RAM read enable
ram_raddr  out  ASIZE  RAM read address
out_valid  out  1  RAM read data is a valid L-delayed sample (RAM q, one cycle after ram_re)
fill_cnt  out  LSIZE  accepted samples since flush, saturating at L
state_o  out  2  00 IDLE, 01 FILL, 10 RUN
cfg_err  out  1  sticky flag: an out-of-range length was clamped

Behaviour:
- Reset values: wp=0, fill_cnt=0, active length L_act=WDEPTH, shadow L_sh=WDEPTH, pend=0, state IDLE. All outputs 0, except ram_waddr=0 and ram_raddr=0.
- ram_we = ram_re = in_valid & (state != IDLE). Both are combinational from in_valid.
- ram_waddr = wp.
- ram_raddr = (wp >= L_act) ? wp - L_act : wp + WDEPTH - L_act. Computed in ASIZE+1 bits, then truncated.
- When L_act = WDEPTH, raddr equals waddr. The RAM must be read-first (old data) on same-address access.
- Accepted sample: ram_we high.
  - wp advances: wp = (wp == WDEPTH-1) ? 0 : wp+1.
  - fill_cnt increments, saturating at L_act.
- out_valid is registered: it is high in the cycle after an accepted sample if fill_cnt == L_act at the acceptance edge. Latency from ram_re to out_valid is 1 cycle, matching the RAM read latency.
- Config capture: cfg_load captures cfg_len into L_sh and sets pend.
  - cfg_len = 0 is clamped to 1.
  - cfg_len > WDEPTH is clamped to WDEPTH.
  - Either clamp sets cfg_err. cfg_err clears only on Reset.
- Config apply: L_sh is copied to L_act, pend is cleared, and a flush occurs when either of these holds:
  - state is IDLE and pend is set;
  - frame_start is high and pend is set.
- Flush: wp=0, fill_cnt=0, out_valid=0 next cycle.
- State machine:
  - IDLE -> FILL when enable=1 (with config apply and flush on that edge).
  - FILL -> RUN on the edge where fill_cnt reaches L_act.
  - RUN -> FILL on frame_start (flush).
  - FILL -> FILL on frame_start (flush).
  - Any state -> IDLE when enable=0: flush; in_valid is ignored while IDLE.
- Simultaneous events:
  - frame_start and in_valid in the same cycle: flush first, then the sample is written at address 0, so wp=1 and fill_cnt=1. The read for that sample is not valid (out_valid=0).
  - cfg_load and frame_start in the same cycle: the new cfg_len is captured and applied on that same edge.
  - enable=0 dominates frame_start and cfg apply. cfg_load is still captured while enable=0.
- L_act = 1: out_valid follows every accepted sample from the second sample onward. raddr = wp-1 with wrap: at wp=0, raddr = WDEPTH-1.
- Reset mid-operation: all state returns to reset values immediately; out_valid drops asynchronously.

Test Plan:
- Reset, cfg_len=4 with cfg_load, enable=1, then in_valid continuously with pixel data = count. Required: state FILL -> RUN after 4 samples; first out_valid one cycle after the 5th accept; ram_raddr trails ram_waddr by 4; delayed data equals count-4.
- L=640, stream 1300 samples. Required: ram_waddr wraps 639 -> 0; raddr == waddr throughout; out_valid first asserted after sample 641; fill_cnt holds at 640.
- L=15 loaded mid-RUN (old L=4), then frame_start. Required: L_act stays 4 until frame_start; at frame_start, flush with wp=0 and fill_cnt=0; next RUN entry after 15 samples.
- cfg_len=0, then cfg_len=700. Required: L_act clamps to 1, then to 640; cfg_err=1 and stays set until Reset.
- frame_start coincident with in_valid in RUN at wp=123. Required: next cycle wp=1, fill_cnt=1, out_valid=0.
- Gapped in_valid (1 of every 3 cycles), L=5. Required: wp and fill_cnt advance only on valid cycles; out_valid pulses only one cycle after valid accepts.
- Assert Reset mid-stream for 100 ns. Required: all outputs return to reset values; restart behaves as in the first scenario.
